freq_meas_ctrl: RTL and testbench
=================================

Name: freq_meas_ctrl

Overview:
Sequencer directly upstream and downstream of the frequency measurement stage. Accepts a measurement command (gate length in Clock cycles) over a valid/ready handshake and drives the measurement stage's n_cycles and rising-edge-triggered enable. It waits for done, captures the free-running edge counter, and returns the modular edge-count difference as a result over a second valid/ready handshake. A watchdog catches a measurement stage that never signals done.

Parameters:
DATA_WIDTH, 16, width of cycle/edge counts; must match the measurement stage
TIMEOUT_MARGIN, 8, extra cycles beyond the gate length before RUN is declared timed out
AVG_SHIFT, 2, log2 of measurements per command when FREQ_CTRL_AVG_EN is defined

Ports:
Clock  in  1  system clock
nReset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_cycles  in  DATA_WIDTH  gate length in Clock cycles
meas_n_cycles  out  DATA_WIDTH  to measurement stage n_cycles
meas_enable  out  1  to measurement stage enable_in; one-cycle pulse
meas_edge_count  in  DATA_WIDTH  from measurement stage edge_count (free-running, wraps)
meas_done  in  1  from measurement stage done_flag
res_valid  out  1  result present
res_ready  in  1  consumer accepts result
res_count  out  DATA_WIDTH  edges counted in gate
res_cycles  out  DATA_WIDTH  gate length used
res_err  out  1  1 = timeout or illegal command

Behaviour:
- Reset values: cmd_ready=0, meas_enable=0, meas_n_cycles=all-ones, res_valid=0, res_count=0, res_cycles=0, res_err=0, state=IDLE.
- meas_n_cycles resets to all-ones so the idle measurement stage (cycle_count=0) never reports a spurious done.
- States: IDLE, ARM, RUN, DRAIN, RESULT.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, register cmd_cycles into meas_n_cycles and res_cycles.
  - cmd_cycles=0 → RESULT with res_err=1, res_count=0. No pulse is issued.
  - Otherwise → ARM.
- ARM (1 cycle): meas_enable=1, start snapshot <= meas_edge_count, clear watchdog → RUN. meas_enable is low in every other state, so each pulse gives the stage a fresh rising edge.
- RUN: watchdog increments each cycle.
  - meas_done=1 → DRAIN.
  - Watchdog reaches meas_n_cycles+TIMEOUT_MARGIN without done (DATA_WIDTH+1-bit compare, no overflow) → RESULT with res_err=1, res_count=0.
  - meas_done and the timeout in the same cycle: done wins.
- DRAIN (1 cycle): res_count <= (meas_edge_count − start) mod 2^DATA_WIDTH, res_err=0 → RESULT. The one-cycle delay includes any edge counted on the done cycle.
- RESULT: res_valid=1; res_count/res_cycles/res_err stable while res_valid&!res_ready. On res_ready → IDLE, res_valid=0 next cycle.
- cmd_ready=1 only in IDLE; no command is accepted while a result is pending.
- meas_done outside RUN is ignored.
- Latency: command accept → meas_enable 1 cycle; meas_done → res_valid 2 cycles.
- Asynchronous reset mid-operation returns all outputs to reset values immediately; any in-flight measurement is abandoned.
- After reset, the first command must still give correct wrap-safe results.

Optional Feature:
Macro FREQ_CTRL_AVG_EN.
- Defined: each command runs 2^AVG_SHIFT back-to-back ARM/RUN/DRAIN passes.
  - Each pass's difference is added into a DATA_WIDTH+AVG_SHIFT accumulator.
  - res_count = accumulator >> AVG_SHIFT (truncate).
  - Any pass timing out aborts the remaining passes: res_err=1, res_count=0.
- Not defined: single pass, no accumulator logic.

Test Plan:
- Single measurement: bench model edge_count=100 at ARM, done after 1000 enabled cycles, edge_count=200 → res_count=100, res_cycles=1000, res_err=0; res_valid exactly 2 cycles after meas_done.
- Wrap-around: edge_count=0xFFF0 at ARM, 0x0054 at DRAIN → res_count=0x0064.
- Timeout: cmd_cycles=50, meas_done never asserted → res_valid after 58 RUN cycles, res_err=1, res_count=0; cmd_cycles=0 → immediate res_err=1, meas_enable never pulsed.
- Backpressure: hold res_ready=0 for 20 cycles → res fields stable, cmd_ready=0, second cmd_valid not accepted; accepted in IDLE after res_ready=1.
- Reset in RUN: assert nReset=0 mid-gate → meas_enable=0, meas_n_cycles=0xFFFF, res_valid=0 within the same cycle; next command yields a correct result.
- FREQ_CTRL_AVG_EN, AVG_SHIFT=2: pass differences 100, 101, 99, 103 → res_count=100; exactly 4 meas_enable pulses, each separated by ≥1 low cycle.

Source files
------------

// File: rtl/freq_meas_ctrl.sv
// freq_meas_ctrl: command/result sequencer wrapped around the frequency
// measurement stage. It takes a gate length over a valid/ready handshake,
// pulses the stage's enable, waits for done, and returns the modular
// edge-count difference. A watchdog covers a stage that never signals done.
// Optional feature macro: FREQ_CTRL_AVG_EN (average 2^AVG_SHIFT passes per
// command).
module freq_meas_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_MARGIN = 8,
  parameter int AVG_SHIFT      = 2
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_cycles,
  output logic [DATA_WIDTH-1:0] meas_n_cycles,
  output logic                  meas_enable,
  input  logic [DATA_WIDTH-1:0] meas_edge_count,
  input  logic                  meas_done,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_count,
  output logic [DATA_WIDTH-1:0] res_cycles,
  output logic                  res_err
);

  typedef enum logic [2:0] {IDLE, ARM, RUN, DRAIN, RESULT} state_e;

  // One extra bit so gate length plus margin never overflows the compare.
  localparam int WD_W = DATA_WIDTH + 1;

  if (AVG_SHIFT < 0 || AVG_SHIFT > 16) begin : g_bad_avg_shift
    $error("freq_meas_ctrl: AVG_SHIFT must lie in 0..16");
  end

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] n_cycles_q, n_cycles_d;
  logic [DATA_WIDTH-1:0] res_cycles_q, res_cycles_d;
  logic [DATA_WIDTH-1:0] res_count_q, res_count_d;
  logic                  res_err_q, res_err_d;
  logic [DATA_WIDTH-1:0] start_q, start_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  meas_enable_q, meas_enable_d;
  logic                  res_valid_q, res_valid_d;

  logic [DATA_WIDTH-1:0] diff;
  logic [WD_W-1:0]       wd_limit;

  // Free-running counter wraps, so plain modular subtraction is wrap-safe.
  assign diff     = meas_edge_count - start_q;
  assign wd_limit = {1'b0, n_cycles_q} + WD_W'(TIMEOUT_MARGIN);

`ifdef FREQ_CTRL_AVG_EN
  localparam int                 ACC_W     = DATA_WIDTH + AVG_SHIFT;
  localparam logic [AVG_SHIFT:0] PASS_LAST = (AVG_SHIFT + 1)'((1 << AVG_SHIFT) - 1);

  logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
  logic [AVG_SHIFT:0] pass_q, pass_d;

  assign acc_sum = acc_q + ACC_W'(diff);
`endif

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    n_cycles_d   = n_cycles_q;
    res_cycles_d = res_cycles_q;
    res_count_d  = res_count_q;
    res_err_d    = res_err_q;
    start_d      = start_q;
    wd_d         = wd_q;
`ifdef FREQ_CTRL_AVG_EN
    acc_d        = acc_q;
    pass_d       = pass_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          n_cycles_d   = cmd_cycles;
          res_cycles_d = cmd_cycles;
          if (cmd_cycles == '0) begin
            res_err_d   = 1'b1;
            res_count_d = '0;
            state_d     = RESULT;
          end else begin
`ifdef FREQ_CTRL_AVG_EN
            acc_d  = '0;
            pass_d = '0;
`endif
            state_d = ARM;
          end
        end
      end
      ARM: begin
        start_d = meas_edge_count;
        wd_d    = '0;
        state_d = RUN;
      end
      RUN: begin
        wd_d = wd_q + WD_W'(1);
        if (meas_done) begin
          state_d = DRAIN;
        end else if (wd_d >= wd_limit) begin
          res_err_d   = 1'b1;
          res_count_d = '0;
          state_d     = RESULT;
        end
      end
      DRAIN: begin
`ifdef FREQ_CTRL_AVG_EN
        if (pass_q == PASS_LAST) begin
          res_count_d = DATA_WIDTH'(acc_sum >> AVG_SHIFT);
          res_err_d   = 1'b0;
          state_d     = RESULT;
        end else begin
          acc_d   = acc_sum;
          pass_d  = pass_q + (AVG_SHIFT + 1)'(1);
          state_d = ARM;
        end
`else
        res_count_d = diff;
        res_err_d   = 1'b0;
        state_d     = RESULT;
`endif
      end
      RESULT: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d   = (state_d == IDLE);
    meas_enable_d = (state_d == ARM);
    res_valid_d   = (state_d == RESULT);
  end

  // State and output registers; n_cycles idles at all-ones so an idle stage
  // never matches its cycle count and raises a spurious done.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q       <= IDLE;
      n_cycles_q    <= '1;
      res_cycles_q  <= '0;
      res_count_q   <= '0;
      res_err_q     <= 1'b0;
      start_q       <= '0;
      wd_q          <= '0;
      cmd_ready_q   <= 1'b0;
      meas_enable_q <= 1'b0;
      res_valid_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q       <= state_d;
      n_cycles_q    <= n_cycles_d;
      res_cycles_q  <= res_cycles_d;
      res_count_q   <= res_count_d;
      res_err_q     <= res_err_d;
      start_q       <= start_d;
      wd_q          <= wd_d;
      cmd_ready_q   <= cmd_ready_d;
      meas_enable_q <= meas_enable_d;
      res_valid_q   <= res_valid_d;
    end
  end

`ifdef FREQ_CTRL_AVG_EN
  // Averaging accumulator and pass counter.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      acc_q  <= '0;
      pass_q <= '0;
    end else begin
      acc_q  <= acc_d;
      pass_q <= pass_d;
    end
  end
`endif

  assign cmd_ready     = cmd_ready_q;
  assign meas_n_cycles = n_cycles_q;
  assign meas_enable   = meas_enable_q;
  assign res_valid     = res_valid_q;
  assign res_count     = res_count_q;
  assign res_cycles    = res_cycles_q;
  assign res_err       = res_err_q;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// tb_freq_meas_ctrl: directed and randomized commands against a plan-based
// reference: the bench chooses start counts, modular differences and done
// timing per pass, and expects res_count = (sum of differences) / passes.
module tb_freq_meas_ctrl;

  localparam int DW     = 16;
  localparam int MARGIN = 8;
  localparam int SHIFT  = 2;
`ifdef FREQ_CTRL_AVG_EN
  localparam int PASSES = 1 << SHIFT;
`else
  localparam int PASSES = 1;
`endif

  logic          Clock = 1'b0;
  logic          nReset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] cmd_cycles = '0;
  logic [DW-1:0] meas_n_cycles;
  logic          meas_enable;
  logic [DW-1:0] meas_edge_count = '0;
  logic          meas_done = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_count;
  logic [DW-1:0] res_cycles;
  logic          res_err;

  int n_checks  = 0;
  int n_errors  = 0;
  int pulse_cnt = 0;

  // Per-pass plan for the next command; plan_done = 0 means done never comes.
  logic [DW-1:0] plan_start [PASSES];
  logic [DW-1:0] plan_diff  [PASSES];
  int            plan_done  [PASSES];

  freq_meas_ctrl #(
    .DATA_WIDTH    (DW),
    .TIMEOUT_MARGIN(MARGIN),
    .AVG_SHIFT     (SHIFT)
  ) dut (
    .Clock          (Clock),
    .nReset         (nReset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_cycles     (cmd_cycles),
    .meas_n_cycles  (meas_n_cycles),
    .meas_enable    (meas_enable),
    .meas_edge_count(meas_edge_count),
    .meas_done      (meas_done),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_count      (res_count),
    .res_cycles     (res_cycles),
    .res_err        (res_err)
  );

  always #5 Clock = ~Clock;

  // Count cycles with enable high (each pulse is one cycle wide).
  always @(negedge Clock) if (meas_enable === 1'b1) pulse_cnt++;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete in time");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 10) begin
      @(negedge Clock);
      n++;
    end
    check("cmd_ready_idle", cmd_ready, 1);
  endtask

  // Run one command through all planned passes, then hold the result for
  // 'hold' cycles of backpressure before accepting it.
  task automatic do_cmd(input logic [DW-1:0] cyc, input int hold);
    int            p0, arms, k, acc, to_k;
    bit            failed, stable;
    logic [DW-1:0] exp_count;
    logic          exp_err;

    wait_ready();
    p0     = pulse_cnt;
    arms   = 0;
    acc    = 0;
    failed = (cyc == '0);
    cmd_valid  = 1'b1;
    cmd_cycles = cyc;
    @(negedge Clock);
    cmd_valid  = 1'b0;
    cmd_cycles = 16'($urandom);

    for (int p = 0; p < PASSES && !failed; p++) begin
      arms++;
      check("arm_enable", meas_enable, 1);
      check("arm_n_cycles", meas_n_cycles, cyc);
      meas_edge_count = plan_start[p];
      @(negedge Clock);
      to_k = (plan_done[p] == 0) ? int'(cyc) + MARGIN : 0;
      k = 1;
      forever begin
        meas_edge_count = 16'($urandom);
        if (k == plan_done[p]) begin
          meas_done = 1'b1;
          @(negedge Clock);
          meas_done = 1'b0;
          check("drain_valid", res_valid, 0);
          check("drain_enable", meas_enable, 0);
          meas_edge_count = plan_start[p] + plan_diff[p];
          acc += int'(plan_diff[p]);
          @(negedge Clock);
          break;
        end
        @(negedge Clock);
        if (res_valid === 1'b1) begin
          check("timeout_after", k, to_k);
          failed = 1'b1;
          break;
        end
        if (k > int'(cyc) + MARGIN + 4) begin
          check("watchdog_bound", k, to_k);
          failed = 1'b1;
          break;
        end
        k++;
      end
    end

    exp_err   = failed;
    exp_count = failed ? '0 : 16'(acc / PASSES);
    check("res_valid", res_valid, 1);
    check("res_count", res_count, exp_count);
    check("res_cycles", res_cycles, cyc);
    check("res_err", res_err, exp_err);
    check("cmd_ready_busy", cmd_ready, 0);

    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      cmd_valid       = 1'b1;
      cmd_cycles      = 16'($urandom_range(1, 9));
      meas_done       = 1'($urandom);
      meas_edge_count = 16'($urandom);
      @(negedge Clock);
      if (res_valid !== 1'b1 || res_count !== exp_count || res_cycles !== cyc ||
          res_err !== exp_err || cmd_ready !== 1'b0 || meas_enable !== 1'b0)
        stable = 1'b0;
    end
    if (hold > 0) check("hold_stable", stable, 1);

    cmd_valid = 1'b0;
    meas_done = 1'b0;
    res_ready = 1'b1;
    @(negedge Clock);
    res_ready = 1'b0;
    check("post_valid", res_valid, 0);
    check("post_ready", cmd_ready, 1);
    check("enable_pulses", pulse_cnt - p0, arms);
  endtask

  // Abandon a measurement with an asynchronous reset; run_cycles = 0 hits
  // the enable cycle itself.
  task automatic reset_during(input int run_cycles);
    wait_ready();
    cmd_valid  = 1'b1;
    cmd_cycles = 16'd300;
    @(negedge Clock);
    cmd_valid       = 1'b0;
    meas_edge_count = 16'($urandom);
    repeat (run_cycles) @(negedge Clock);
    #2 nReset = 1'b0;
    #1;
    check("rst_enable", meas_enable, 0);
    check("rst_n_cycles", meas_n_cycles, 16'hFFFF);
    check("rst_valid", res_valid, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_cycles", res_cycles, 0);
    @(negedge Clock);
    nReset = 1'b1;
  endtask

  task automatic plan_all(input logic [DW-1:0] start, input logic [DW-1:0] diff, input int done_at);
    for (int p = 0; p < PASSES; p++) begin
      plan_start[p] = start;
      plan_diff[p]  = diff;
      plan_done[p]  = done_at;
    end
  endtask

  initial begin
    logic [DW-1:0] cyc;
    int            dtab [4];
    dtab = '{100, 101, 99, 103};

    #1 nReset = 1'b0;
    #1;
    check("reset_cmd_ready", cmd_ready, 0);
    check("reset_enable", meas_enable, 0);
    check("reset_n_cycles", meas_n_cycles, 16'hFFFF);
    check("reset_res_valid", res_valid, 0);
    check("reset_res_count", res_count, 0);
    check("reset_res_cycles", res_cycles, 0);
    check("reset_res_err", res_err, 0);
    repeat (3) @(negedge Clock);
    nReset = 1'b1;

    // Single measurement: start 100, 100 edges, done after 1000 cycles.
    for (int p = 0; p < PASSES; p++) begin
      plan_start[p] = 16'd100;
      plan_diff[p]  = 16'(dtab[p]);
      plan_done[p]  = 1000;
    end
    do_cmd(16'd1000, 0);

    // Wrap-around: 0xFFF0 -> 0x0054.
    plan_all(16'hFFF0, 16'h0064, 10);
    do_cmd(16'd20, 0);

    // Timeout with done never raised, then zero-length command.
    plan_all(16'd5, 16'd7, 0);
    do_cmd(16'd50, 0);
    do_cmd(16'd0, 0);

    // Done on the very cycle the watchdog would fire: done wins.
    plan_all(16'd1234, 16'd4321, 12 + MARGIN);
    do_cmd(16'd12, 0);

    // Backpressure for 20 cycles with a competing command pending.
    plan_all(16'h8000, 16'h0FFF, 7);
    do_cmd(16'd9, 20);

`ifdef FREQ_CTRL_AVG_EN
    // Timeout on the last pass aborts the whole command.
    plan_all(16'd10, 16'd20, 3);
    plan_done[PASSES-1] = 0;
    do_cmd(16'd6, 0);
`endif

    // Reset in the enable cycle and mid-gate; next command must be correct.
    reset_during(0);
    plan_all(16'hFFFE, 16'd3, 5);
    do_cmd(16'd8, 0);
    reset_during(40);
    plan_all(16'h7FFF, 16'hFFFF, 30);
    do_cmd(16'd30, 1);

    // Randomized commands.
    for (int t = 0; t < 40; t++) begin
      cyc = 16'($urandom_range(1, 40));
      for (int p = 0; p < PASSES; p++) begin
        plan_start[p] = 16'($urandom);
        plan_diff[p]  = 16'($urandom);
        plan_done[p]  = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, int'(cyc) + MARGIN));
      end
      do_cmd(cyc, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
